mixer_n_gain: RTL and testbench

- Parametrised N-channel audio mixer with per-channel unsigned gain, per-channel mute and output saturation.
- Successor to the fixed two-input half-and-half mixer.
- Runs in the bclk domain; one mix is computed per lrclk frame by a time-multiplexed multiply-accumulate, one channel per bclk cycle.
- Sits between the sources (oscillators, codec inputs) and the I2S transmitter.

---
 rtl/mixer_pkg.sv | 49 ++++
 rtl/mac_slice.sv | 46 ++++
 rtl/mixer_n_gain.sv | 173 +++++++++++++++++
 tb/tb_mixer_n_gain.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/mixer_pkg.sv
// Shared types and helpers for the N-channel gain mixer.
package mixer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    OUTPUT = 2'd2
  } state_t;

  // Saturation result: clamped value plus a flag telling whether clamping happened.
  typedef struct packed {
    logic               clip;
    logic signed [63:0] val;
  } sat_t;

  // Ceiling log2, used only on elaboration-time constants.
  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return r;
  endfunction

  // Clamp a wide signed value into a signed field of the given bit count.
  function automatic sat_t sat_trunc(input logic signed [63:0] value, input int bits);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    sat_t               r;
    hi = (64'sd1 <<< (bits - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (bits - 1));
    if (value > hi) begin
      r.val  = hi;
      r.clip = 1'b1;
    end else if (value < lo) begin
      r.val  = lo;
      r.clip = 1'b1;
    end else begin
      r.val  = value;
      r.clip = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/mac_slice.sv
// Registered signed-sample x unsigned-gain multiply-accumulate with clear and enable.
module mac_slice #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 8,
  parameter int ACC_W  = 27
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     clr_i,
  input  logic                     en_i,
  input  logic signed [DATA_W-1:0] sample_i,
  input  logic        [COEF_W-1:0] coef_i,
  output logic signed [ACC_W-1:0]  acc_o
);

  localparam int PROD_W = DATA_W + COEF_W + 1;

  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  acc_q;
  logic signed [ACC_W-1:0]  acc_d;

  // Gain is zero-extended by one bit so it multiplies as a non-negative signed value.
  assign prod = PROD_W'(sample_i) * PROD_W'($signed({1'b0, coef_i}));

  // Next accumulator value: clear wins over accumulate.
  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = acc_q + ACC_W'(prod);
    end
  end

  // Accumulator register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/mixer_n_gain.sv
// N-channel mixer: per-channel gain and mute, one channel per bclk, saturated output per frame.
module mixer_n_gain
  import mixer_pkg::*;
#(
  parameter int BITSIZE  = 16,
  parameter int CHANNELS = 4,
  parameter int GAINBITS = 8
) (
  input  logic                           bclk,
  input  logic                           resetn,
  input  logic                           lrclk,
  input  logic [CHANNELS*BITSIZE-1:0]    in,
  input  logic [CHANNELS*GAINBITS-1:0]   gain,
  input  logic [CHANNELS-1:0]            mute,
  output logic signed [BITSIZE-1:0]      out,
  output logic                           out_valid,
  output logic                           clip,
  output logic                           overrun
);

  localparam int PRODW = BITSIZE + GAINBITS + 1;
  localparam int ACCW  = PRODW + clog2(CHANNELS);
  localparam int IDXW  = (CHANNELS > 1) ? clog2(CHANNELS) : 1;
  localparam logic [IDXW-1:0] LAST = IDXW'(CHANNELS - 1);

  state_t                       state_q, state_d;
  logic [IDXW-1:0]              idx_q, idx_d;
  logic                         lr_d1_q, lr_d2_q;
  logic                         start;
  logic                         snap, mac_clr, mac_en, publish;

  logic [CHANNELS*BITSIZE-1:0]  in_q;
  logic [CHANNELS*GAINBITS-1:0] gain_q;
  logic [CHANNELS-1:0]          mute_q;

  logic signed [BITSIZE-1:0]    sample_sel;
  logic [GAINBITS-1:0]          gain_sel;
  logic signed [ACCW-1:0]       acc;
  logic signed [ACCW-1:0]       shifted;
  sat_t                         sat;
  logic                         unused_sat_hi;

  logic signed [BITSIZE-1:0]    out_q;
  logic                         out_valid_q, clip_q, overrun_q;

  assign start = lr_d1_q & ~lr_d2_q;

  // lrclk history and sticky overrun flag.
  always_ff @(posedge bclk or negedge resetn) begin
    if (!resetn) begin
      lr_d1_q   <= 1'b0;
      lr_d2_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      lr_d1_q <= lrclk;
      lr_d2_q <= lr_d1_q;
      if (start && (state_q != IDLE)) begin
        overrun_q <= 1'b1;
      end
    end
  end

  // State and channel index registers.
  always_ff @(posedge bclk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state and index logic.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ACCUM;
          idx_d   = '0;
        end
      end
      ACCUM: begin
        idx_d = idx_q + 1'b1;
        if (idx_q == LAST) begin
          state_d = OUTPUT;
        end
      end
      OUTPUT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control strobes decoded from the current state.
  always_comb begin
    snap    = 1'b0;
    mac_clr = 1'b0;
    mac_en  = 1'b0;
    publish = 1'b0;
    case (state_q)
      IDLE: begin
        snap    = start;
        mac_clr = start;
      end
      ACCUM:   mac_en  = 1'b1;
      OUTPUT:  publish = 1'b1;
      default: ;
    endcase
  end

  // Frame snapshot; later input changes do not disturb the frame in progress.
  always_ff @(posedge bclk) begin
    if (snap) begin
      in_q   <= in;
      gain_q <= gain;
      mute_q <= mute;
    end
  end

  // Muted channels feed a zero sample so their product vanishes.
  always_comb begin
    sample_sel = in_q[idx_q*BITSIZE +: BITSIZE];
    gain_sel   = gain_q[idx_q*GAINBITS +: GAINBITS];
    if (mute_q[idx_q]) begin
      sample_sel = '0;
    end
  end

  mac_slice #(
    .DATA_W (BITSIZE),
    .COEF_W (GAINBITS),
    .ACC_W  (ACCW)
  ) u_mac (
    .clk_i    (bclk),
    .rst_n_i  (resetn),
    .clr_i    (mac_clr),
    .en_i     (mac_en),
    .sample_i (sample_sel),
    .coef_i   (gain_sel),
    .acc_o    (acc)
  );

  // Remove the unity-gain scale (floor toward -inf), then clamp to the sample range.
  always_comb begin
    shifted = acc >>> (GAINBITS - 1);
    sat     = sat_trunc({{(64 - ACCW){shifted[ACCW-1]}}, shifted}, BITSIZE);
  end

  assign unused_sat_hi = ^sat.val[63:BITSIZE];

  // Output stage: publish once per frame, hold between frames.
  always_ff @(posedge bclk or negedge resetn) begin
    if (!resetn) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
      clip_q      <= 1'b0;
    end else begin
      out_valid_q <= publish;
      if (publish) begin
        out_q  <= sat.val[BITSIZE-1:0];
        clip_q <= sat.clip;
      end
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign clip      = clip_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_mixer_n_gain.sv
// Scoreboard bench for mixer_n_gain (BITSIZE=16, CHANNELS=4, GAINBITS=8).
module tb_mixer_n_gain;

  logic        bclk;
  logic        resetn;
  logic        lrclk;
  logic [63:0] in_v;
  logic [31:0] gain_v;
  logic [3:0]  mute_v;
  logic signed [15:0] out;
  logic        out_valid;
  logic        clip;
  logic        overrun;

  typedef struct {
    int o;
    bit c;
    int cy;
  } exp_t;

  exp_t q[$];
  int   cyc;
  int   checks;
  int   errors;

  mixer_n_gain #(
    .BITSIZE  (16),
    .CHANNELS (4),
    .GAINBITS (8)
  ) dut (
    .bclk      (bclk),
    .resetn    (resetn),
    .lrclk     (lrclk),
    .in        (in_v),
    .gain      (gain_v),
    .mute      (mute_v),
    .out       (out),
    .out_valid (out_valid),
    .clip      (clip),
    .overrun   (overrun)
  );

  initial bclk = 1'b0;
  always #5 bclk = ~bclk;

  initial cyc = 0;
  always @(posedge bclk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every out_valid pulse must match the oldest expected frame.
  always @(negedge bclk) begin
    if (resetn && out_valid) begin
      if (q.size() == 0) begin
        checks = checks + 1;
        errors = errors + 1;
        $display("FAIL unexpected_valid: got out=%0d with no frame expected", out);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("out", int'(out), e.o);
        check("clip", int'(clip), int'(e.c));
        check("latency_cycle", cyc, e.cy);
      end
    end
  end

  task automatic set_ch(input int k, input int s, input int g, input bit m);
    logic [15:0] s16;
    logic [7:0]  g8;
    s16 = 16'(s);
    g8  = 8'(g);
    in_v[k*16 +: 16] = s16;
    gain_v[k*8 +: 8] = g8;
    mute_v[k]        = m;
  endtask

  task automatic clear_all();
    in_v   = '0;
    gain_v = '0;
    mute_v = '0;
  endtask

  // Issue one frame; called right after a falling bclk edge.
  task automatic frame(input int eo, input bit ec);
    exp_t e;
    e.o  = eo;
    e.c  = ec;
    e.cy = cyc + 7;
    q.push_back(e);
    lrclk = 1'b1;
    repeat (2) @(negedge bclk);
    lrclk = 1'b0;
    repeat (10) @(negedge bclk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int wait_n;
    exp_t e;
    checks = 0;
    errors = 0;
    resetn = 1'b0;
    lrclk  = 1'b0;
    clear_all();
    repeat (3) @(negedge bclk);
    check("reset_out", int'(out), 0);
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_clip", int'(clip), 0);
    check("reset_overrun", int'(overrun), 0);
    resetn = 1'b1;
    repeat (3) @(negedge bclk);

    // Half gain: (1000 - 400) * 64 >> 7 = 300
    clear_all();
    for (int k = 0; k < 4; k++) set_ch(k, 0, 64, 1'b0);
    set_ch(0, 1000, 64, 1'b0);
    set_ch(1, -400, 64, 1'b0);
    frame(300, 1'b0);

    // Saturation high and low
    for (int k = 0; k < 4; k++) set_ch(k, 32767, 255, 1'b0);
    frame(32767, 1'b1);
    for (int k = 0; k < 4; k++) set_ch(k, -32768, 255, 1'b0);
    frame(-32768, 1'b1);

    // Unity gain clears clip
    clear_all();
    for (int k = 0; k < 4; k++) set_ch(k, 0, 128, 1'b0);
    set_ch(0, 100, 128, 1'b0);
    frame(100, 1'b0);

    // Floor toward -inf
    clear_all();
    set_ch(0, -1, 64, 1'b0);
    frame(-1, 1'b0);
    set_ch(0, 1, 64, 1'b0);
    frame(0, 1'b0);

    // Mute drops channel 1
    clear_all();
    set_ch(0, 10, 128, 1'b0);
    set_ch(1, 5000, 128, 1'b1);
    frame(10, 1'b0);

    // Snapshot: input change after the start does not affect this frame
    clear_all();
    for (int k = 0; k < 4; k++) set_ch(k, 0, 128, 1'b0);
    set_ch(0, 1000, 128, 1'b0);
    e.o = 1000; e.c = 1'b0; e.cy = cyc + 7;
    q.push_back(e);
    lrclk = 1'b1;
    repeat (2) @(negedge bclk);
    set_ch(0, -7000, 128, 1'b0);
    lrclk = 1'b0;
    repeat (10) @(negedge bclk);
    frame(-7000, 1'b0);

    // lrclk held high: only one start
    set_ch(0, 42, 128, 1'b0);
    e.o = 42; e.c = 1'b0; e.cy = cyc + 7;
    q.push_back(e);
    lrclk = 1'b1;
    repeat (20) @(negedge bclk);
    lrclk = 1'b0;
    repeat (20) @(negedge bclk);
    check("out_hold", int'(out), 42);

    // Reset mid-frame aborts; no pulse expected
    set_ch(0, 555, 128, 1'b0);
    lrclk = 1'b1;
    repeat (3) @(negedge bclk);
    resetn = 1'b0;
    lrclk  = 1'b0;
    #1;
    check("abort_out", int'(out), 0);
    check("abort_out_valid", int'(out_valid), 0);
    repeat (2) @(negedge bclk);
    resetn = 1'b1;
    repeat (10) @(negedge bclk);
    check("abort_no_publish", int'(out), 0);
    set_ch(0, 200, 128, 1'b0);
    frame(200, 1'b0);
    check("no_overrun_yet", int'(overrun), 0);

    // Overrun: second edge 3 cycles after the first
    set_ch(0, 300, 128, 1'b0);
    e.o = 300; e.c = 1'b0; e.cy = cyc + 7;
    q.push_back(e);
    lrclk = 1'b1;
    @(negedge bclk);
    lrclk = 1'b0;
    repeat (2) @(negedge bclk);
    lrclk = 1'b1;
    @(negedge bclk);
    lrclk = 1'b0;
    repeat (12) @(negedge bclk);
    check("overrun_set", int'(overrun), 1);
    set_ch(0, -20, 128, 1'b0);
    frame(-20, 1'b0);
    check("overrun_sticky", int'(overrun), 1);
    resetn = 1'b0;
    #1;
    check("overrun_cleared", int'(overrun), 0);
    @(negedge bclk);
    resetn = 1'b1;
    repeat (3) @(negedge bclk);

    wait_n = 0;
    while (q.size() != 0 && wait_n < 50) begin
      @(negedge bclk);
      wait_n++;
    end
    check("pending_frames", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
